mc_control_fsm: RTL and testbench

//  Multicycle RV32I control unit. It drives the ALU's ALUControl and datapath mux selects, and it consumes
//  the ALU's Zero/Negative/Carry/Overflow flags to resolve branches. Moore FSM plus a combinational ALU decoder.

---
 rtl/mc_control_fsm_pkg.sv | 60 ++++++
 rtl/mc_alu_decoder.sv | 44 ++++
 rtl/mc_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// ALU control codes, datapath mux selects and the opcodes it recognises.
package mc_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_EXEC_I = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JAL    = 4'd10
   } state_t;

   // ALUControl codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALUOp from the FSM to the ALU decoder
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // ResultSrc selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALUSrcB selects
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ImmSrc formats
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: turns ALUOp plus the instruction's funct fields into an
// ALUControl code, and flags funct3 values the ALU path cannot execute.
module mc_alu_decoder
   import mc_control_fsm_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic [1:0] alu_op,
   output logic [2:0] alu_control,
   output logic       alu_illegal
);

   // alu_illegal depends on funct3 only, so the FSM can use it in DECODE
   // while ALUOp is still forcing an add for the target computation.
   always_comb begin
      alu_illegal = 1'b0;
      case (funct3)
         3'b000, 3'b010, 3'b110, 3'b111: alu_illegal = 1'b0;
         default:                        alu_illegal = 1'b1;
      endcase
   end

   // Select the ALU operation: fixed add/sub, or decoded from funct fields.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALU_OP_ADD: alu_control = ALU_ADD;
         ALU_OP_SUB: alu_control = ALU_SUB;
         ALU_OP_FUNCT: begin
            case (funct3)
               // op5 separates R-type from addi; addi never subtracts
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: Moore FSM driving the datapath enables and
// mux selects, with branch resolution from the ALU flags. The current state
// is exported on dbg_state for observation.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter bit UNSIGNED_BR = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       Negative,
   input  logic       Carry,
   input  logic       Overflow,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic       Illegal,
   output logic [3:0] dbg_state
);

   state_t     state;
   state_t     state_next;
   logic [1:0] alu_op;
   logic       alu_illegal;
   logic       taken;
   logic       branch_legal;
   logic       pc_update;
   logic       branch;
   logic       mem_write_raw;
   logic       ir_write_raw;
   logic       reg_write_raw;
   logic       illegal_raw;

   mc_alu_decoder u_alu_decoder (
      .op5         (op[5]),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_op      (alu_op),
      .alu_control (ALUControl),
      .alu_illegal (alu_illegal)
   );

   // State register; reset lands in FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   assign dbg_state = state;

   // Branch condition from the ALU flags of a SrcA - SrcB subtraction.
   always_comb begin
      taken        = 1'b0;
      branch_legal = 1'b0;
      case (funct3)
         3'b000: begin taken = Zero;                    branch_legal = 1'b1;        end
         3'b001: begin taken = ~Zero;                   branch_legal = 1'b1;        end
         3'b100: begin taken = Negative ^ Overflow;     branch_legal = 1'b1;        end
         3'b101: begin taken = ~(Negative ^ Overflow);  branch_legal = 1'b1;        end
         3'b110: begin taken = ~Carry;                  branch_legal = UNSIGNED_BR; end
         3'b111: begin taken = Carry;                   branch_legal = UNSIGNED_BR; end
         default: begin taken = 1'b0;                   branch_legal = 1'b0;        end
      endcase
   end

   // Immediate format is a pure function of the opcode.
   always_comb begin
      ImmSrc = IMM_I;
      case (op)
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         default:   ImmSrc = IMM_I;
      endcase
   end

   // Next state and Moore outputs; unknown encodings fall back to FETCH.
   always_comb begin
      state_next    = S_FETCH;
      pc_update     = 1'b0;
      branch        = 1'b0;
      AdrSrc        = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_RS2;
      alu_op        = ALU_OP_ADD;
      case (state)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            ALUSrcB      = SRCB_FOUR;
            ResultSrc    = RES_ALURESULT;
            pc_update    = 1'b1;
            state_next   = S_DECODE;
         end
         S_DECODE: begin
            // OldPC + imm lands in ALUOut as the branch/jal target
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_R: begin
                  if (alu_illegal) illegal_raw = 1'b1;
                  else             state_next  = S_EXEC_R;
               end
               OP_I: begin
                  if (alu_illegal) illegal_raw = 1'b1;
                  else             state_next  = S_EXEC_I;
               end
               OP_BRANCH: begin
                  if (branch_legal) state_next  = S_BRANCH;
                  else              illegal_raw = 1'b1;
               end
               OP_JAL:  state_next  = S_JAL;
               default: illegal_raw = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            state_next = op[5] ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            AdrSrc     = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc     = RES_DATA;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_MEMWR: begin
            AdrSrc        = 1'b1;
            mem_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_EXEC_R: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            alu_op     = ALU_OP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXEC_I: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            alu_op     = ALU_OP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            alu_op     = ALU_OP_SUB;
            branch     = 1'b1;
            state_next = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            pc_update  = 1'b1;
            state_next = S_ALUWB;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Enables are gated by rst_n so a falling reset kills any write at once,
   // not just at the next edge.
   assign PCWrite  = rst_n & (pc_update | (branch & taken));
   assign MemWrite = rst_n & mem_write_raw;
   assign IRWrite  = rst_n & ir_write_raw;
   assign RegWrite = rst_n & reg_write_raw;
   assign Illegal  = rst_n & illegal_raw;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: an instruction-level model expands
// each instruction into its expected per-cycle output vectors, and a single
// negedge compare process checks the DUT against them.
module tb_mc_control_fsm;

   // opcodes, written out independently of the design package
   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_B   = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111;

   // output vector {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,Illegal}
   localparam logic [16:0] M_PCW  = 17'h10000;
   localparam logic [16:0] M_ADR  = 17'h08000;
   localparam logic [16:0] M_MEMW = 17'h04000;
   localparam logic [16:0] M_IRW  = 17'h02000;
   localparam logic [16:0] M_RES  = 17'h01800;
   localparam logic [16:0] M_ALU  = 17'h00070;
   localparam logic [16:0] M_IMM  = 17'h0000C;
   localparam logic [16:0] M_RW   = 17'h00002;
   localparam logic [16:0] M_ILL  = 17'h00001;
   localparam logic [16:0] M_ALL  = 17'h1FFFF;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n, rst1_n;
   always #5 clk = ~clk;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, negative, carry, overflow;

   logic       pcw, adr, memw, irw, regw, ill;
   logic [1:0] res, srca, srcb, imm;
   logic [2:0] aluc;
   logic [3:0] dbg;
   logic       pcw1, adr1, memw1, irw1, regw1, ill1;
   logic [1:0] res1, srca1, srcb1, imm1;
   logic [2:0] aluc1;
   logic [3:0] dbg1;

   mc_control_fsm #(.UNSIGNED_BR(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(zero), .Negative(negative), .Carry(carry), .Overflow(overflow),
      .PCWrite(pcw), .AdrSrc(adr), .MemWrite(memw), .IRWrite(irw),
      .ResultSrc(res), .ALUSrcA(srca), .ALUSrcB(srcb), .ALUControl(aluc),
      .ImmSrc(imm), .RegWrite(regw), .Illegal(ill), .dbg_state(dbg)
   );

   mc_control_fsm #(.UNSIGNED_BR(1'b0)) u_dut_nou (
      .clk(clk), .rst_n(rst1_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(zero), .Negative(negative), .Carry(carry), .Overflow(overflow),
      .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(memw1), .IRWrite(irw1),
      .ResultSrc(res1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .ALUControl(aluc1),
      .ImmSrc(imm1), .RegWrite(regw1), .Illegal(ill1), .dbg_state(dbg1)
   );

   logic [16:0] act, act1;
   assign act  = {pcw, adr, memw, irw, res, srca, srcb, aluc, imm, regw, ill};
   assign act1 = {pcw1, adr1, memw1, irw1, res1, srca1, srcb1, aluc1, imm1, regw1, ill1};

   // scoreboard
   logic [16:0] exp_q[$];
   logic [16:0] cmp_e;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [16:0] got,
                        input logic [16:0] want, input logic [16:0] mask);
      n_cmp++;
      if ((got & mask) !== (want & mask)) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (mask %h) at %0t", nm, got & mask, want & mask, mask, $time);
      end
   endtask

   function automatic logic [16:0] mk(input logic p, input logic a, input logic mw, input logic iw,
                                      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] al, input logic rw, input logic il,
                                      input logic [1:0] im);
      return {p, a, mw, iw, rs, sa, sb, al, im, rw, il};
   endfunction

   // reference model: instruction -> sequence of expected cycle outputs
   task automatic push_model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic n, input logic c, input logic v,
                             input bit unsigned_br, output int len);
      logic [1:0] im;
      logic [2:0] al;
      logic       tk;
      bit         alu_ok, br_ok;
      im = (o == T_SW) ? 2'b01 : (o == T_B) ? 2'b10 : (o == T_JAL) ? 2'b11 : 2'b00;
      alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
      br_ok  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5) ||
               (unsigned_br && (f3 == 3'd6 || f3 == 3'd7));
      al = (f3 == 3'd0) ? ((o == T_R && f7) ? 3'b001 : 3'b000) :
           (f3 == 3'd2) ? 3'b101 : (f3 == 3'd6) ? 3'b011 : 3'b010;
      case (f3)
         3'd0:    tk = z;
         3'd1:    tk = !z;
         3'd4:    tk = n ^ v;
         3'd5:    tk = !(n ^ v);
         3'd6:    tk = !c;
         default: tk = c;
      endcase
      exp_q.push_back(mk(1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, 0, 0, im));   // fetch
      if (o == T_LW || o == T_SW) begin
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 0, im));
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0, 0, im));
         if (o == T_LW) begin
            exp_q.push_back(mk(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0, im));
            exp_q.push_back(mk(0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 1, 0, im));
            len = 5;
         end else begin
            exp_q.push_back(mk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 0, im));
            len = 4;
         end
      end else if ((o == T_R || o == T_I) && alu_ok) begin
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 0, im));
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd2, (o == T_R) ? 2'd0 : 2'd1, al, 0, 0, im));
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0, im));
         len = 4;
      end else if (o == T_B && br_ok) begin
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 0, im));
         exp_q.push_back(mk(tk, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 0, 0, im));
         len = 3;
      end else if (o == T_JAL) begin
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 0, im));
         exp_q.push_back(mk(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0, 0, im));
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0, im));
         len = 4;
      end else begin
         exp_q.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0, 1, im));
         len = 2;
      end
   endtask

   // compare process: one expected vector per cycle while the queue holds work
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cmp_e = exp_q.pop_front();
         check("cycle_outputs", act, cmp_e, M_ALL);
      end
   end

   // driver: called just after a posedge with the DUT in FETCH; optionally
   // adds one literal check in cycle 'at' of the instruction
   task automatic run_chk(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, input logic n, input logic c, input logic v,
                          input int at, input string nm,
                          input logic [16:0] mask, input logic [16:0] want);
      int len;
      op = o; funct3 = f3; funct7b5 = f7;
      zero = z; negative = n; carry = c; overflow = v;
      push_model(o, f3, f7, z, n, c, v, 1'b1, len);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (k == at) check(nm, act, want, mask);
      end
      @(posedge clk);
      #1;
   endtask

   logic [6:0] ops_tbl[6];
   logic [6:0] r_op;

   initial begin
      ops_tbl[0] = T_LW; ops_tbl[1] = T_SW; ops_tbl[2] = T_R;
      ops_tbl[3] = T_I;  ops_tbl[4] = T_B;  ops_tbl[5] = T_JAL;
      rst_n = 1'b0; rst1_n = 1'b0;
      op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      zero = 1'b0; negative = 1'b0; carry = 1'b0; overflow = 1'b0;

      // reset state: enables low, selects at their FETCH values
      #2;
      check("reset_outputs", act, mk(0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0, 0, 2'd0), M_ALL);

      // unsigned branches disabled: bltu is illegal for one DECODE cycle
      op = T_B; funct3 = 3'b110;
      @(posedge clk); #1; rst1_n = 1'b1; #1;
      check("nou_fetch", act1, M_IRW, M_IRW | M_ILL);
      @(posedge clk); @(negedge clk);
      check("nou_bltu_illegal", act1, M_ILL, M_ILL | M_RW | M_MEMW | M_PCW);
      @(posedge clk); @(negedge clk);
      check("nou_back_fetch", act1, M_IRW, M_IRW | M_ILL);
      rst1_n = 1'b0;

      // main DUT out of reset, directed instructions with literal pins
      @(posedge clk); #1; rst_n = 1'b1;
      run_chk(T_LW, 3'd2, 0, 0, 0, 0, 0, 5, "lw_writeback", M_RW | M_RES, 17'h00802);
      run_chk(T_R,  3'd0, 1, 0, 0, 0, 0, 3, "r_sub",        M_ALU, 17'h00010);
      run_chk(T_I,  3'd0, 1, 0, 0, 0, 0, 3, "addi_add",     M_ALU, 17'h00000);
      run_chk(T_B,  3'd0, 0, 1, 0, 0, 0, 3, "beq_taken",    M_PCW, M_PCW);
      run_chk(T_B,  3'd1, 0, 1, 0, 0, 0, 3, "bne_not",      M_PCW, 17'h0);
      run_chk(T_B,  3'd4, 0, 0, 0, 0, 1, 3, "blt_taken",    M_PCW, M_PCW);
      run_chk(T_B,  3'd6, 0, 0, 0, 0, 0, 3, "bltu_taken",   M_PCW, M_PCW);
      run_chk(T_B,  3'd7, 0, 0, 0, 0, 0, 3, "bgeu_not",     M_PCW, 17'h0);
      run_chk(7'h7F, 3'd0, 0, 0, 0, 0, 0, 2, "bad_op",      M_ILL | M_RW | M_MEMW, M_ILL);
      run_chk(T_R,  3'd1, 0, 0, 0, 0, 0, 2, "r_bad_funct3", M_ILL, M_ILL);
      run_chk(T_B,  3'd2, 0, 0, 0, 0, 0, 2, "b_bad_funct3", M_ILL, M_ILL);
      run_chk(T_SW, 3'd2, 0, 0, 0, 0, 0, 4, "sw_write",     M_MEMW | M_ADR | M_RW, M_MEMW | M_ADR);
      run_chk(T_JAL, 3'd0, 0, 0, 0, 0, 0, 2, "jal_decode",  M_IMM | M_ILL, 17'h0000C);

      // randomized instruction stream
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) r_op = 7'($urandom);
         else                           r_op = ops_tbl[$urandom_range(0, 5)];
         run_chk(r_op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 0, "none", 17'h0, 17'h0);
      end

      // async reset in the middle of a store
      op = T_SW; funct3 = 3'd2; funct7b5 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("memwr_active", act, M_MEMW | M_ADR, M_MEMW | M_ADR);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", act, mk(0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0, 0, 2'd0), M_ALL & ~M_IMM);
      @(posedge clk); #1; rst_n = 1'b1;
      run_chk(T_R, 3'd7, 0, 0, 0, 0, 0, 1, "restart_fetch", M_IRW | M_PCW, M_IRW | M_PCW);
      run_chk(T_LW, 3'd2, 0, 0, 0, 0, 0, 4, "lw_memrd", M_ADR | M_RW, M_ADR);

      check("queue_drained", {16'd0, exp_q.size() == 0}, 17'd1, 17'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
